led_pattern_gen: RTL and testbench

Parametrised multi-mode LED pattern generator for iCE40 board bring-up and status designs. It derives a slow step tick from the global-buffered fabric clock through a programmable power-of-two prescaler. On each tick it advances one of four patterns over `NUM_LEDS` outputs: Gray count, binary count, bounce scan, or PWM breathe. Outputs are registered and drive `SB_IO` output cells (PIN_TYPE 0110_01) directly.

---
 rtl/led_pattern_pkg.sv | 15 +
 rtl/led_prescaler.sv | 24 ++
 rtl/led_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pattern_pkg;

    // Pattern selector; encoding matches the 2-bit mode input.
    typedef enum logic [1:0] {
        GRAY    = 2'd0,
        BINARY  = 2'd1,
        SCAN    = 2'd2,
        BREATHE = 2'd3
    } led_mode_t;

    // Pattern active straight out of reset.
    localparam led_mode_t LED_MODE_RESET = GRAY;

endpackage

// File: rtl/led_prescaler.sv
// Power-of-two prescaler: one tick every 2^LOG2DELAY enabled cycles.
module led_prescaler #(
    parameter int LOG2DELAY = 22
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    logic [LOG2DELAY-1:0] r_pre;

    // Free-running count while enabled; wraps to zero on the tick edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre <= '0;
        end else if (enable) begin
            r_pre <= r_pre + LOG2DELAY'(1);
        end
    end

    assign tick = enable && (r_pre == '1);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: Gray/binary count, bounce scan, PWM breathe.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS  = 5,
    parameter int LOG2DELAY = 22,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_strobe
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic                w_tick;
    led_mode_t           w_mode;
    logic [NUM_LEDS-1:0] w_image;

    led_mode_t           r_cur_mode;
    logic [NUM_LEDS-1:0] r_cnt;
    logic [POS_W-1:0]    r_pos;
    logic                r_dir_down;   // scan direction, 0 = towards higher bits
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_b_down; // breathe direction, 0 = brightening
    logic                r_tick_d;
    logic [PWM_BITS-1:0] r_pwm;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_strobe;

    led_prescaler #(
        .LOG2DELAY(LOG2DELAY)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .enable(enable),
        .tick  (w_tick)
    );

    assign w_mode = led_mode_t'(mode);

    // Mode/pattern FSM: a tick either adopts a new mode (restart at origin) or advances one step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cur_mode   <= LED_MODE_RESET;
            r_cnt        <= '0;
            r_pos        <= '0;
            r_dir_down   <= 1'b0;
            r_duty       <= '0;
            r_dir_b_down <= 1'b0;
            r_tick_d     <= 1'b0;
        end else begin
            r_tick_d <= w_tick;
            if (w_tick) begin
                if (w_mode != r_cur_mode) begin
                    r_cur_mode   <= w_mode;
                    r_cnt        <= '0;
                    r_pos        <= '0;
                    r_dir_down   <= 1'b0;
                    r_duty       <= '0;
                    r_dir_b_down <= 1'b0;
                end else begin
                    case (r_cur_mode)
                        GRAY, BINARY: begin
                            r_cnt <= r_cnt + NUM_LEDS'(1);
                        end
                        SCAN: begin
                            if (NUM_LEDS > 1) begin
                                if (!r_dir_down) begin
                                    if (r_pos == POS_LAST) begin
                                        r_dir_down <= 1'b1;
                                        r_pos      <= POS_LAST - POS_W'(1);
                                    end else begin
                                        r_pos <= r_pos + POS_W'(1);
                                    end
                                end else begin
                                    if (r_pos == '0) begin
                                        r_dir_down <= 1'b0;
                                        r_pos      <= POS_W'(1);
                                    end else begin
                                        r_pos <= r_pos - POS_W'(1);
                                    end
                                end
                            end
                        end
                        default: begin
                            if (!r_dir_b_down) begin
                                if (r_duty == DUTY_MAX) begin
                                    r_dir_b_down <= 1'b1;
                                    r_duty       <= DUTY_MAX - PWM_BITS'(1);
                                end else begin
                                    r_duty <= r_duty + PWM_BITS'(1);
                                end
                            end else begin
                                if (r_duty == '0) begin
                                    r_dir_b_down <= 1'b0;
                                    r_duty       <= PWM_BITS'(1);
                                end else begin
                                    r_duty <= r_duty - PWM_BITS'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    // PWM ramp runs every cycle so a frozen duty still produces a steady glow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_BITS'(1);
        end
    end

    // Image of the current pattern state.
    always_comb begin
        w_image = '0;
        case (r_cur_mode)
            GRAY:    w_image = r_cnt ^ (r_cnt >> 1);
            BINARY:  w_image = r_cnt;
            SCAN:    w_image = NUM_LEDS'(1) << r_pos;
            default: w_image = {NUM_LEDS{(r_pwm < r_duty)}};
        endcase
    end

    // Output register: the image lands one cycle after the state update, with the strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_leds   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_leds   <= w_image;
            r_strobe <= r_tick_d;
        end
    end

    assign leds        = r_leds;
    assign step_strobe = r_strobe;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: NUM_LEDS=5 and NUM_LEDS=1 instances driven in lockstep.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [1:0] mode;
    logic [4:0] leds;
    logic       step_strobe;
    logic [0:0] leds1;
    logic       strobe1;

    int total = 0;
    int bad   = 0;

    // Reference model: mode, steps since pattern origin, enabled cycles, cycles since reset.
    int m_mode, m_k, m_en, m_cyc;
    bit m_tickd;

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(5), .LOG2DELAY(3), .PWM_BITS(4)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
        .leds(leds), .step_strobe(step_strobe)
    );

    led_pattern_gen #(.NUM_LEDS(1), .LOG2DELAY(3), .PWM_BITS(4)) dut1 (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
        .leds(leds1), .step_strobe(strobe1)
    );

    // Pattern image after k steps from origin, computed from the pattern definitions.
    function automatic logic [4:0] img(input int n, input int md, input int k, input int c);
        int v, p, d;
        logic [4:0] r;
        r = '0;
        case (md)
            0: begin v = k % (1 << n); r = 5'(v ^ (v >> 1)); end
            1: r = 5'(k % (1 << n));
            2: begin
                if (n == 1) p = 0;
                else begin
                    p = k % (2 * (n - 1));
                    if (p >= n) p = 2 * (n - 1) - p;
                end
                r = 5'(1 << p);
            end
            default: begin
                d = k % 30;
                if (d > 15) d = 30 - d;
                r = ((c % 16) < d) ? 5'((1 << n) - 1) : 5'd0;
            end
        endcase
        return r;
    endfunction

    task automatic chk5(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_en    = 0;
        m_cyc   = 0;
        m_tickd = 0;
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, check after the edge.
    task automatic cyc();
        logic [4:0] e5, e1;
        logic       es;
        bit         t;
        e5 = img(5, m_mode, m_k, m_cyc);
        e1 = img(1, m_mode, m_k, m_cyc);
        es = m_tickd;
        t  = enable && ((m_en % 8) == 7);
        if (t) begin
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_k    = 0;
            end else begin
                m_k++;
            end
        end
        m_tickd = t;
        if (enable) m_en++;
        m_cyc++;
        @(posedge clk);
        #1;
        chk5("leds", leds, e5);
        chk1("strobe", step_strobe, es);
        chk1("leds1", leds1[0], e1[0]);
        chk1("strobe1", strobe1, es);
    endtask

    task automatic cyc_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [4:0] gray_exp [4];
        logic [4:0] scan_exp [6];
        int         hi_cnt;
        int         guard;
        logic [4:0] pimg;

        gray_exp = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};
        scan_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100};

        // Reset state
        resetn = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk5("rst_leds", leds, 5'b00000);
        chk1("rst_strobe", step_strobe, 1'b0);
        model_reset();
        resetn = 1'b1;

        // Gray count; first step visible 9 cycles after release
        cyc_n(1);
        for (int i = 0; i < 4; i++) begin
            cyc_n(8);
            chk5("gray_seq", leds, gray_exp[i]);
            chk1("gray_strobe", step_strobe, 1'b1);
        end

        // Binary: origin, 31 advances to all-ones, then wrap
        mode = 2'd1;
        cyc_n(8);
        chk5("bin_origin", leds, 5'b00000);
        cyc_n(31 * 8);
        chk5("bin_full", leds, 5'b11111);
        cyc_n(8);
        chk5("bin_wrap", leds, 5'b00000);

        // Scan bounce (the single-LED instance must stay lit)
        mode = 2'd2;
        cyc_n(8);
        chk5("scan_origin", leds, 5'b00001);
        chk1("scan1_origin", leds1[0], 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc_n(8);
            chk5("scan_seq", leds, scan_exp[i]);
            chk1("scan1_seq", leds1[0], 1'b1);
        end

        // Mode glitch between ticks must not restart the gray count
        mode = 2'd0;
        cyc_n(8);
        chk5("gray_restart", leds, 5'b00000);
        cyc_n(3);
        mode = 2'd2;
        cyc_n(2);
        mode = 2'd0;
        cyc_n(3);
        chk5("glitch_step1", leds, 5'b00001);
        cyc_n(8);
        chk5("glitch_step2", leds, 5'b00011);

        // Breathe ramp up to duty 7, then freeze and measure the duty cycle
        mode = 2'd3;
        cyc_n(8);
        cyc_n(56);
        enable = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            hi_cnt += int'(leds[0]);
        end
        chki("breathe_frozen_duty", hi_cnt, 7);
        enable = 1'b1;
        cyc_n(8 * 40);

        // Random mode and enable activity
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            cyc();
        end

        // Reach scan position 3, then reset asynchronously mid-cycle
        enable = 1'b1;
        mode   = 2'd2;
        guard  = 0;
        do begin
            cyc();
            guard++;
            pimg = img(5, m_mode, m_k, 0);
        end while (!(m_mode == 2 && pimg == 5'b01000) && guard < 200);
        chki("scan_pos3_reached", int'(guard < 200), 1);
        cyc();
        chk5("scan_pos3", leds, 5'b01000);
        resetn = 1'b0;
        #1;
        chk5("async_rst_leds", leds, 5'b00000);
        chk1("async_rst_strobe", step_strobe, 1'b0);
        chk1("async_rst_leds1", leds1[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk5("held_rst_leds", leds, 5'b00000);
        mode = 2'd0;
        model_reset();
        resetn = 1'b1;
        cyc_n(8);
        chk5("post_rst_origin", leds, 5'b00000);
        cyc_n(1);
        chk5("post_rst_gray1", leds, 5'b00001);
        cyc_n(8 * 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
